// File: rtl/texture_pkg.sv
// Shared types and constants for the texture fetch path.
package texture_pkg;

    localparam int TEX_ADDR_W = 17;
    localparam int TEXEL_W    = 32;
    localparam int COORD_W    = 12;

    localparam logic [TEXEL_W-1:0] BORDER_COLOR = 32'h0000_0000;

    typedef logic signed [COORD_W-1:0] tex_coord_t;
    typedef logic [TEX_ADDR_W-1:0]     tex_addr_t;
    typedef logic [TEXEL_W-1:0]        texel_t;

    // Clamp a signed coordinate into [0, lim-1].
    function automatic int clamp_coord(input tex_coord_t c, input int lim);
        int ci;
        ci = int'(c);
        if (ci < 0)
            return 0;
        if (ci >= lim)
            return lim - 1;
        return ci;
    endfunction

endpackage

// File: rtl/tex_fetch_fifo.sv
// First-word-fall-through FIFO holding fetched texels until the consumer takes them.
module tex_fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 41,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i)
                mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/texture_fetch_unit.sv
// Texture fetch unit: converts (u,v) requests to RAM addresses, tracks the
// two-stage RAM read pipeline and buffers returned texels with credit flow control.
// Optional feature macro: TEX_CLAMP_EN (clamp out-of-range coordinates instead of
// returning BORDER_COLOR).
module texture_fetch_unit
    import texture_pkg::*;
#(
    parameter int TEX_W    = 320,
    parameter int TEX_H    = 320,
    parameter int TEX_BASE = 0,
    parameter int TAG_W    = 8,
    parameter int DEPTH    = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  tex_coord_t       req_u,
    input  tex_coord_t       req_v,
    input  logic [TAG_W-1:0] req_tag,
    output tex_addr_t        read_address,
    input  texel_t           ram_q,
    output logic             out_valid,
    input  logic             out_ready,
    output texel_t           out_texel,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_border,
    output logic             busy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = CW + 1;
    localparam int FW = TEXEL_W + TAG_W + 1;

    int               u_c, v_c;
    logic             in_range;
    tex_addr_t        addr_d;
    logic             border_d;
    logic             accept;

    tex_addr_t        read_addr_q;
    logic             s1_valid_q, s1_border_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic             s2_valid_q, s2_border_q;
    logic [TAG_W-1:0] s2_tag_q;

    logic [FW-1:0]    fifo_din, fifo_dout;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full, fifo_empty, pop;
    logic [IW-1:0]    inflight;

    // Address compute: the RAM is always read at the clamped address, border flag only without clamping.
    always_comb begin
        u_c      = clamp_coord(req_u, TEX_W);
        v_c      = clamp_coord(req_v, TEX_H);
        in_range = (u_c == int'(req_u)) && (v_c == int'(req_v));
        addr_d   = tex_addr_t'(TEX_BASE + v_c * TEX_W + u_c);
`ifdef TEX_CLAMP_EN
        border_d = 1'b0;
`else
        border_d = !in_range;
`endif
    end

    assign accept = req_valid && req_ready;

    // S1: register the read address and request sideband; address holds when idle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            read_addr_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_tag_q    <= '0;
            s1_border_q <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                read_addr_q <= addr_d;
                s1_tag_q    <= req_tag;
                s1_border_q <= border_d;
            end
        end
    end

    // S2: sideband aligned with the RAM output register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s2_valid_q  <= 1'b0;
            s2_tag_q    <= '0;
            s2_border_q <= 1'b0;
        end else begin
            s2_valid_q  <= s1_valid_q;
            s2_tag_q    <= s1_tag_q;
            s2_border_q <= s1_border_q;
        end
    end

    assign fifo_din = {(s2_border_q ? BORDER_COLOR : ram_q), s2_tag_q, s2_border_q};
    assign pop      = out_valid && out_ready;

    tex_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .push_i  (s2_valid_q),
        .data_i  (fifo_din),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Credit invariant: a push into a full FIFO must coincide with a pop.
    always_ff @(posedge clk) begin
        if (n_rst)
            assert (!(fifo_full && s2_valid_q && !pop));
    end

    // Credits count every entry already committed to a FIFO slot; a same-cycle pop is not credited.
    assign inflight  = IW'(fifo_count) + IW'(s1_valid_q) + IW'(s2_valid_q);
    assign req_ready = n_rst && (inflight < IW'(DEPTH));
    assign busy      = (inflight != '0);

    assign read_address                     = read_addr_q;
    assign out_valid                        = !fifo_empty;
    assign {out_texel, out_tag, out_border} = fifo_dout;

endmodule

// File: tb/tb_texture_fetch_unit.sv
// Scoreboard bench for texture_fetch_unit with a registered-read RAM model.
module tb_texture_fetch_unit;
    import texture_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       out_ready = 1'b0;
    tex_coord_t req_u = '0;
    tex_coord_t req_v = '0;
    logic [7:0] req_tag = '0;
    tex_addr_t  read_address;
    texel_t     ram_q;
    texel_t     out_texel;
    logic       req_ready, out_valid, out_border, busy;
    logic [7:0] out_tag;

    typedef struct { texel_t texel; logic [7:0] tag; logic border; } exp_t;
    typedef struct { int u; int v; int a; bit inr; } vec_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    vec_t t2[8] = '{'{0,0,0,1}, '{1,0,1,1}, '{319,0,319,1}, '{0,1,320,1},
                    '{10,10,3210,1}, '{319,319,102399,1}, '{100,200,64100,1}, '{7,3,967,1}};
    vec_t t3[6] = '{'{2,0,2,1}, '{3,0,3,1}, '{4,0,4,1}, '{5,0,5,1}, '{6,0,6,1}, '{7,0,7,1}};
    vec_t t5[6] = '{'{1,1,321,1}, '{-5,-5,0,0}, '{0,320,102080,0},
                    '{20,0,20,1}, '{319,-1,319,0}, '{2047,2047,102399,0}};

    texture_fetch_unit #(
        .TEX_W    (320),
        .TEX_H    (320),
        .TEX_BASE (0),
        .TAG_W    (8),
        .DEPTH    (4)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_u        (req_u),
        .req_v        (req_v),
        .req_tag      (req_tag),
        .read_address (read_address),
        .ram_q        (ram_q),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_texel    (out_texel),
        .out_tag      (out_tag),
        .out_border   (out_border),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Texture RAM: mem[a] = a ^ 32'hA5A5_0000, one-cycle registered read.
    always @(posedge clk) ram_q <= {15'b0, read_address} ^ 32'hA5A5_0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input int a, input bit inr, input logic [7:0] tag);
        exp_t e;
        e.tag = tag;
`ifdef TEX_CLAMP_EN
        e.border = 1'b0;
        e.texel  = a ^ 32'hA5A5_0000;
`else
        e.border = !inr;
        e.texel  = inr ? (a ^ 32'hA5A5_0000) : 32'h0;
`endif
        return e;
    endfunction

    task automatic send(input vec_t vv, input logic [7:0] tag, output int stall);
        @(negedge clk);
        req_valid = 1'b1;
        req_u     = tex_coord_t'(vv.u);
        req_v     = tex_coord_t'(vv.v);
        req_tag   = tag;
        stall     = 0;
        #1;
        while (!req_ready && stall < 100) begin
            @(negedge clk);
            #1;
            stall++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: tag %h never accepted", tag);
        end else begin
            sb.push_back(model(vv.a, vv.inr, tag));
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_remaining", sb.size(), 0);
    endtask

    // Monitor: every transfer on the output port is compared with the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (n_rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_texel: got tag %h texel %h expected none", out_tag, out_texel);
                end else begin
                    e = sb.pop_front();
                    check("out_texel", out_texel, e.texel);
                    check("out_tag", {24'b0, out_tag}, {24'b0, e.tag});
                    check("out_border", {31'b0, out_border}, {31'b0, e.border});
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, base, acc, idx;
        vec_t vv;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_read_address", read_address, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_texel", out_texel, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_border", out_border, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        check("post_rst_req_ready", req_ready, 1);
        out_ready = 1'b1;

        // Single request, address and latency
        vv = '{5, 2, 645, 1'b1};
        send(vv, 8'h03, st);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("t1_read_address", read_address, 645);
        check("t1_valid_e0", out_valid, 0);
        @(negedge clk);
        #1;
        check("t1_valid_e1", out_valid, 0);
        @(negedge clk);
        #1;
        check("t1_valid_e2", out_valid, 1);
        drain();

        // Back-to-back stream
        base = pop_cyc.size();
        for (int i = 0; i < 8; i++) begin
            send(t2[i], 8'h10 + 8'(i), st);
            check("t2_no_stall", st, 0);
        end
        idle();
        drain();
        for (int i = 1; i < 8; i++)
            check("t2_consecutive", pop_cyc[base + i] - pop_cyc[base], i);

        // Backpressure fills exactly DEPTH credits
        out_ready = 1'b0;
        idx = 0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_u     = tex_coord_t'(t3[idx].u);
            req_v     = tex_coord_t'(t3[idx].v);
            req_tag   = 8'h20 + 8'(idx);
            #1;
            if (req_ready) begin
                sb.push_back(model(t3[idx].a, t3[idx].inr, req_tag));
                idx++;
                acc++;
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("t3_accepted", acc, 4);
        check("t3_ready_full", req_ready, 0);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("t3_ready_same_cycle_pop", req_ready, 0);
        @(negedge clk);
        #1;
        check("t3_ready_after_pop", req_ready, 1);
        drain();

        // Out-of-range coordinates
        vv = '{-1, 0, 0, 1'b0};
        send(vv, 8'h40, st);
        idle();
        #1;
        check("t4_addr_neg", read_address, 0);
        vv = '{320, 5, 1919, 1'b0};
        send(vv, 8'h41, st);
        idle();
        #1;
        check("t4_addr_clamp", read_address, 1919);
        drain();

        // Mixed in-range / border ordering
        for (int i = 0; i < 6; i++)
            send(t5[i], 8'h30 + 8'(i), st);
        idle();
        drain();

        // Reset with requests pending
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(t2[i], 8'h60 + 8'(i), st);
        idle();
        #1;
        check("t6_busy_before", busy, 1);
        check("t6_valid_before", out_valid, 1);
        n_rst = 1'b0;
        #1;
        sb.delete();
        check("t6_req_ready", req_ready, 0);
        check("t6_read_address", read_address, 0);
        check("t6_out_valid", out_valid, 0);
        check("t6_out_texel", out_texel, 0);
        check("t6_out_tag", out_tag, 0);
        check("t6_out_border", out_border, 0);
        check("t6_busy", busy, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check("t6_no_emit", out_valid, 0);
        end
        check("t6_busy_after", busy, 0);
        check("t6_ready_after", req_ready, 1);
        check("final_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
